ide_disk_multi: RTL
===================

Name: ide_disk_multi

Overview:
- Multi-sector, parametrised IDE/ATA block-transfer engine in PIO mode; successor to the single-sector disk controller.
- Moves N consecutive 256-word sectors between a word buffer and the drive, starting at a given LBA.
- Drives the existing ATA register-access engine through its rd/wr/addr/done handshake.
- Adds per-sector DRQ polling, poll timeouts, error codes and LBA28 high-nibble support.

Parameters:
- LBA_W, 28: LBA width, at most 28; upper bits are zero-extended.
- WORD_W, 12: buffer word width, at most 16.
- CNT_W, 8: sector-count width; the buffer address is CNT_W+8 bits.
- TMO_W, 20: poll-timeout counter width; the timeout is 2^TMO_W-1 cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- ide_lba  in  LBA_W  start LBA
- ide_count  in  CNT_W  sector count; 0 means 2^CNT_W
- ide_read_req  in  1  start read (level)
- ide_write_req  in  1  start write (level); has priority over read
- ide_done  out  1  idle/complete flag
- ide_error  out  1  last transfer failed
- ide_err_code  out  2  0 none, 1 timeout, 2 device ERR
- buffer_addr  out  CNT_W+8  {sector index, word offset}
- buffer_rd  out  1  buffer read strobe; data is valid one cycle later
- buffer_wr  out  1  buffer write strobe
- buffer_in  in  WORD_W  buffer read data
- buffer_out  out  WORD_W  buffer write data
- ata_rd, ata_wr  out  1  register access request; held until ata_done
- ata_addr  out  5  ATA register select
- ata_in  out  16  register write data
- ata_out  in  16  register read data; valid with ata_done
- ata_done  in  1  single-cycle access-complete pulse

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high.
- Reset values: ide_done=1, ide_error=0, ide_err_code=0, every strobe 0, addr/data outputs 0, state IDLE.
- Reset mid-operation aborts immediately; the drive is left untouched.
- Request capture: in IDLE, (read_req|write_req) latches lba, count and direction, clears done, error and err_code, and moves to WAIT_RDY.
- Requests arriving outside IDLE are ignored.
- ATA handshake: ata_rd/ata_wr, ata_addr and ata_in are held constant from assertion until the cycle ata_done=1. The state advances on that cycle.
- State sequence:
  - WAIT_RDY: poll STATUS until BSY=0 and DRDY=1.
  - SET_CTRL: DEVCTRL=0x0002.
  - SET_CNT: SECCNT = count truncated to 8 bits.
  - SET_L0, SET_L1, SET_L2: LBA[7:0], LBA[15:8], LBA[23:16].
  - SET_DH: DRVHEAD = 0x0040 | LBA[27:24].
  - SET_CMD: COMMAND = 0x30 for write, 0x20 for read.
- Per-sector loop:
  - POLL_ALT: one ALTSTATUS read (400 ns settle).
  - POLL_DRQ: poll STATUS until BSY=0 and DRQ=1.
  - Read path: RD_DATA issues a DATA read; on ata_done go to RD_STORE. RD_STORE pulses buffer_wr with buffer_out = ata_out[WORD_W-1:0], then increments the word offset.
  - Write path: WR_FETCH pulses buffer_rd. WR_DATA writes DATA with ata_in = zero-extended buffer_in, then increments the offset.
  - When the offset wraps from 255 to 0: decrement the remaining count and increment the sector index. If remaining > 0 go to POLL_ALT, else go to FIN_ALT.
- Finish: FIN_ALT reads ALTSTATUS, then FIN_STAT reads STATUS. If ERR=1 go to ERROR, else DONE. DONE sets done=1 and returns to IDLE.
- Errors:
  - Any STATUS read in WAIT_RDY or POLL_DRQ returning ERR=1 with BSY=0 goes to ERROR with err_code=2.
  - The poll timer resets on entry to each polling state. If it reaches all-ones, go to ERROR with err_code=1.
  - ERROR sets ide_error=1 and done=1, then returns to IDLE.
- Simultaneous read and write request: write wins.
- Count 0 transfers 2^CNT_W sectors, with SECCNT written as 0.
- Buffer address wraps at 2^(CNT_W+8).

Decomposition:
- Shared package ide_pkg holds:
  - ATA register addresses: DATA 10000, ERROR/FEATURE 10001, SECCNT 10010, SECNUM 10011, CYLLOW 10100, CYLHIGH 10101, DRVHEAD 10110, STATUS/COMMAND 10111, ALTSTATUS/DEVCTRL 01110.
  - Status bit indices: BSY 7, DRDY 6, DRQ 3, ERR 0.
  - Command codes 0x20 and 0x30.
  - Error-code constants and the state encoding.
- One natural sub-module, ide_poll_timer: clear/enable inputs and an expire output at TMO_W.

Test Plan:
1. Read, lba=0x0000123, count=1, drive model returns words 0..255 -> register writes SECCNT=1, SECNUM=0x23, CYLLOW=0x01, CYLHIGH=0, DRVHEAD=0x40, CMD=0x20; 256 buffer_wr at addr 0..255 with data k[11:0]; done=1, error=0.
2. Write, lba=0xA5B6C7D, count=3, buffer preloaded -> DRVHEAD=0x4A; 768 DATA writes in address order; DRQ polled before each sector; done=1.
3. Count=0 with CNT_W=2 -> SECCNT written 0; 1024 words transferred; buffer_addr reaches 0x3FF.
4. Drive holds BSY=1 forever, TMO_W=6 -> ERROR within 63 cycles of poll entry; err_code=1, done=1.
5. STATUS=0x41 (ERR) after the command -> no DATA access; err_code=2, error=1.
6. Reset asserted during sector 2 of a 4-sector read -> next cycle done=1 and all strobes 0; a new request then completes normally.

Source files
------------

// File: rtl/ide_pkg.sv
// Shared constants for the multi-sector IDE PIO engine: ATA register map,
// status bits, command codes, error codes and FSM state encoding.
package ide_pkg;

    localparam logic [4:0] REG_DATA    = 5'b10000;
    localparam logic [4:0] REG_ERROR   = 5'b10001;
    localparam logic [4:0] REG_FEATURE = 5'b10001;
    localparam logic [4:0] REG_SECCNT  = 5'b10010;
    localparam logic [4:0] REG_SECNUM  = 5'b10011;
    localparam logic [4:0] REG_CYLLOW  = 5'b10100;
    localparam logic [4:0] REG_CYLHIGH = 5'b10101;
    localparam logic [4:0] REG_DRVHEAD = 5'b10110;
    localparam logic [4:0] REG_STATUS  = 5'b10111;
    localparam logic [4:0] REG_COMMAND = 5'b10111;
    localparam logic [4:0] REG_ALTSTAT = 5'b01110;
    localparam logic [4:0] REG_DEVCTRL = 5'b01110;

    localparam int ST_BSY  = 7;
    localparam int ST_DRDY = 6;
    localparam int ST_DRQ  = 3;
    localparam int ST_ERR  = 0;

    localparam logic [7:0] CMD_READ  = 8'h20;
    localparam logic [7:0] CMD_WRITE = 8'h30;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_DEVICE  = 2'd2
    } err_code_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } ata_req_t;

    localparam logic [4:0] S_IDLE     = 5'd0;
    localparam logic [4:0] S_WAIT_RDY = 5'd1;
    localparam logic [4:0] S_SET_CTRL = 5'd2;
    localparam logic [4:0] S_SET_CNT  = 5'd3;
    localparam logic [4:0] S_SET_L0   = 5'd4;
    localparam logic [4:0] S_SET_L1   = 5'd5;
    localparam logic [4:0] S_SET_L2   = 5'd6;
    localparam logic [4:0] S_SET_DH   = 5'd7;
    localparam logic [4:0] S_SET_CMD  = 5'd8;
    localparam logic [4:0] S_POLL_ALT = 5'd9;
    localparam logic [4:0] S_POLL_DRQ = 5'd10;
    localparam logic [4:0] S_RD_DATA  = 5'd11;
    localparam logic [4:0] S_RD_STORE = 5'd12;
    localparam logic [4:0] S_WR_FETCH = 5'd13;
    localparam logic [4:0] S_WR_DATA  = 5'd14;
    localparam logic [4:0] S_FIN_ALT  = 5'd15;
    localparam logic [4:0] S_FIN_STAT = 5'd16;
    localparam logic [4:0] S_ERROR    = 5'd17;
    localparam logic [4:0] S_DONE     = 5'd18;

    // Device error is only meaningful once the drive has dropped BSY.
    function automatic logic status_err(input logic [15:0] st);
        return !st[ST_BSY] && st[ST_ERR];
    endfunction

endpackage

// File: rtl/ide_disk_multi_if.sv
// Host, word-buffer and ATA register-engine signals of the multi-sector engine.
interface ide_disk_multi_if #(
    parameter int LBA_W  = 28,
    parameter int WORD_W = 12,
    parameter int CNT_W  = 8
);
    logic [LBA_W-1:0]  ide_lba;
    logic [CNT_W-1:0]  ide_count;
    logic              ide_read_req;
    logic              ide_write_req;
    logic              ide_done;
    logic              ide_error;
    logic [1:0]        ide_err_code;
    logic [CNT_W+7:0]  buffer_addr;
    logic              buffer_rd;
    logic              buffer_wr;
    logic [WORD_W-1:0] buffer_in;
    logic [WORD_W-1:0] buffer_out;
    logic              ata_rd;
    logic              ata_wr;
    logic [4:0]        ata_addr;
    logic [15:0]       ata_in;
    logic [15:0]       ata_out;
    logic              ata_done;

    modport master (
        input  ide_lba, ide_count, ide_read_req, ide_write_req,
               buffer_in, ata_out, ata_done,
        output ide_done, ide_error, ide_err_code,
               buffer_addr, buffer_rd, buffer_wr, buffer_out,
               ata_rd, ata_wr, ata_addr, ata_in
    );

    modport slave (
        output ide_lba, ide_count, ide_read_req, ide_write_req,
               buffer_in, ata_out, ata_done,
        input  ide_done, ide_error, ide_err_code,
               buffer_addr, buffer_rd, buffer_wr, buffer_out,
               ata_rd, ata_wr, ata_addr, ata_in
    );
endinterface

// File: rtl/ide_poll_timer.sv
// Poll timeout counter: cleared outside polling, saturates and flags expiry
// when it reaches all-ones.
module ide_poll_timer #(
    parameter int TMO_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);
    logic [TMO_W-1:0] count_q, count_d;

    assign expire_o = &count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (en_i && !expire_o)
            count_d = count_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule

// File: rtl/ide_disk_multi.sv
// Multi-sector PIO transfer engine: programs the task file, then moves
// 256-word sectors between the word buffer and the drive's DATA register.
module ide_disk_multi
    import ide_pkg::*;
#(
    parameter int LBA_W  = 28,
    parameter int WORD_W = 12,
    parameter int CNT_W  = 8,
    parameter int TMO_W  = 20
) (
    input  logic             clk,
    input  logic             reset,
    ide_disk_multi_if.master bus
);
    logic [4:0]        state_q, state_d;
    ata_req_t          req_q, req_d;
    logic              busy_q, busy_d;
    logic              write_q, write_d;
    logic [LBA_W-1:0]  lba_q, lba_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    remain_q, remain_d;
    logic [CNT_W-1:0]  sector_q, sector_d;
    logic [7:0]        offset_q, offset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    err_code_e         code_q, code_d;
    logic [WORD_W-1:0] bufout_q, bufout_d;

    logic [LBA_W+27:0]  lba_ext;
    logic [27:0]        lba28;
    logic [CNT_W+7:0]   cnt_ext;
    logic [WORD_W+15:0] word_ext;
    logic               unused_bits;

    // Widening through a zero-padded vector keeps any parameter mix legal.
    assign lba_ext     = {28'd0, lba_q};
    assign lba28       = lba_ext[27:0];
    assign cnt_ext     = {8'd0, cnt_q};
    assign word_ext    = {16'd0, bus.buffer_in};
    assign unused_bits = ^{lba_ext, cnt_ext, word_ext, bus.ata_out};

    logic poll, tmr_expire;
    assign poll = (state_q == S_WAIT_RDY) || (state_q == S_POLL_DRQ);

    ide_poll_timer #(.TMO_W(TMO_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!poll),
        .en_i     (poll),
        .expire_o (tmr_expire)
    );

    ata_req_t acc;
    logic     acc_en;

    always_comb begin
        acc    = '0;
        acc_en = 1'b1;
        case (state_q)
            S_WAIT_RDY, S_POLL_DRQ, S_FIN_STAT: begin acc.rd = 1'b1; acc.addr = REG_STATUS;  end
            S_POLL_ALT, S_FIN_ALT:              begin acc.rd = 1'b1; acc.addr = REG_ALTSTAT; end
            S_RD_DATA:                          begin acc.rd = 1'b1; acc.addr = REG_DATA;    end
            S_SET_CTRL: begin acc.wr = 1'b1; acc.addr = REG_DEVCTRL; acc.data = 16'h0002; end
            S_SET_CNT:  begin acc.wr = 1'b1; acc.addr = REG_SECCNT;  acc.data = {8'd0, cnt_ext[7:0]}; end
            S_SET_L0:   begin acc.wr = 1'b1; acc.addr = REG_SECNUM;  acc.data = {8'd0, lba28[7:0]}; end
            S_SET_L1:   begin acc.wr = 1'b1; acc.addr = REG_CYLLOW;  acc.data = {8'd0, lba28[15:8]}; end
            S_SET_L2:   begin acc.wr = 1'b1; acc.addr = REG_CYLHIGH; acc.data = {8'd0, lba28[23:16]}; end
            S_SET_DH:   begin acc.wr = 1'b1; acc.addr = REG_DRVHEAD; acc.data = {8'd0, 4'h4, lba28[27:24]}; end
            S_SET_CMD:  begin
                acc.wr   = 1'b1;
                acc.addr = REG_COMMAND;
                acc.data = {8'd0, (write_q ? CMD_WRITE : CMD_READ)};
            end
            S_WR_DATA:  begin acc.wr = 1'b1; acc.addr = REG_DATA; acc.data = word_ext[15:0]; end
            default:    acc_en = 1'b0;
        endcase
    end

    logic fire, adv;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        busy_d   = busy_q;
        write_d  = write_q;
        lba_d    = lba_q;
        cnt_d    = cnt_q;
        remain_d = remain_q;
        sector_d = sector_q;
        offset_d = offset_q;
        done_d   = done_q;
        error_d  = error_q;
        code_d   = code_q;
        bufout_d = bufout_q;
        fire     = 1'b0;
        adv      = 1'b0;

        // One request per access; it drops on ata_done, leaving a gap cycle.
        if (acc_en) begin
            if (!busy_q) begin
                req_d  = acc;
                busy_d = 1'b1;
            end else if (bus.ata_done) begin
                req_d  = '0;
                busy_d = 1'b0;
                fire   = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.ide_write_req || bus.ide_read_req) begin
                    write_d  = bus.ide_write_req;
                    lba_d    = bus.ide_lba;
                    cnt_d    = bus.ide_count;
                    remain_d = {1'b0, bus.ide_count};
                    if (bus.ide_count == '0)
                        remain_d[CNT_W] = 1'b1;
                    sector_d = '0;
                    offset_d = '0;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    code_d   = ERR_NONE;
                    state_d  = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: if (fire) begin
                if (status_err(bus.ata_out)) begin
                    code_d  = ERR_DEVICE;
                    state_d = S_ERROR;
                end else if (!bus.ata_out[ST_BSY] && bus.ata_out[ST_DRDY]) begin
                    state_d = S_SET_CTRL;
                end
            end
            S_SET_CTRL: if (fire) state_d = S_SET_CNT;
            S_SET_CNT:  if (fire) state_d = S_SET_L0;
            S_SET_L0:   if (fire) state_d = S_SET_L1;
            S_SET_L1:   if (fire) state_d = S_SET_L2;
            S_SET_L2:   if (fire) state_d = S_SET_DH;
            S_SET_DH:   if (fire) state_d = S_SET_CMD;
            S_SET_CMD:  if (fire) state_d = S_POLL_ALT;
            S_POLL_ALT: if (fire) state_d = S_POLL_DRQ;
            S_POLL_DRQ: if (fire) begin
                if (status_err(bus.ata_out)) begin
                    code_d  = ERR_DEVICE;
                    state_d = S_ERROR;
                end else if (!bus.ata_out[ST_BSY] && bus.ata_out[ST_DRQ]) begin
                    state_d = write_q ? S_WR_FETCH : S_RD_DATA;
                end
            end
            S_RD_DATA: if (fire) begin
                bufout_d = bus.ata_out[WORD_W-1:0];
                state_d  = S_RD_STORE;
            end
            S_RD_STORE: begin
                adv     = 1'b1;
                state_d = S_RD_DATA;
            end
            S_WR_FETCH: state_d = S_WR_DATA;
            S_WR_DATA: if (fire) begin
                adv     = 1'b1;
                state_d = S_WR_FETCH;
            end
            S_FIN_ALT:  if (fire) state_d = S_FIN_STAT;
            S_FIN_STAT: if (fire) begin
                if (bus.ata_out[ST_ERR]) begin
                    code_d  = ERR_DEVICE;
                    state_d = S_ERROR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_ERROR: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // End of a sector: the last word overrides the in-sector next state.
        if (adv) begin
            offset_d = offset_q + 8'd1;
            if (offset_q == 8'hFF) begin
                remain_d = remain_q - (CNT_W+1)'(1);
                sector_d = sector_q + CNT_W'(1);
                state_d  = (remain_q == (CNT_W+1)'(1)) ? S_FIN_ALT : S_POLL_ALT;
            end
        end

        if (poll && tmr_expire) begin
            req_d   = '0;
            busy_d  = 1'b0;
            code_d  = ERR_TIMEOUT;
            state_d = S_ERROR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            req_q    <= '0;
            busy_q   <= 1'b0;
            write_q  <= 1'b0;
            lba_q    <= '0;
            cnt_q    <= '0;
            remain_q <= '0;
            sector_q <= '0;
            offset_q <= '0;
            done_q   <= 1'b1;
            error_q  <= 1'b0;
            code_q   <= ERR_NONE;
            bufout_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            write_q  <= write_d;
            lba_q    <= lba_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            sector_q <= sector_d;
            offset_q <= offset_d;
            done_q   <= done_d;
            error_q  <= error_d;
            code_q   <= code_d;
            bufout_q <= bufout_d;
        end
    end

    assign bus.ide_done     = done_q;
    assign bus.ide_error    = error_q;
    assign bus.ide_err_code = code_q;
    assign bus.buffer_addr  = {sector_q, offset_q};
    assign bus.buffer_rd    = (state_q == S_WR_FETCH);
    assign bus.buffer_wr    = (state_q == S_RD_STORE);
    assign bus.buffer_out   = bufout_q;
    assign bus.ata_rd       = req_q.rd;
    assign bus.ata_wr       = req_q.wr;
    assign bus.ata_addr     = req_q.addr;
    assign bus.ata_in       = req_q.data;
endmodule
